// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the handshaked LSU: load/store type codes and FSM states.
// Helper used only when YSYX_22041211_LSU_ALIGN_CHECK_EN is defined.
package ysyx_22041211_lsu_pkg;

    localparam logic [2:0] LOAD_NONE = 3'b000;
    localparam logic [2:0] LOAD_LB   = 3'b001;
    localparam logic [2:0] LOAD_LBU  = 3'b010;
    localparam logic [2:0] LOAD_LH   = 3'b011;
    localparam logic [2:0] LOAD_LHU  = 3'b100;
    localparam logic [2:0] LOAD_LW   = 3'b101;

    localparam logic [1:0] STORE_NONE = 2'b00;
    localparam logic [1:0] STORE_SB   = 2'b01;
    localparam logic [1:0] STORE_SH   = 2'b10;
    localparam logic [1:0] STORE_SW   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_RESP = 2'b10,
        S_DONE = 2'b11
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] st,
                                           input logic [1:0] a);
        logic half;
        logic word;
        half = (lt == LOAD_LH) || (lt == LOAD_LHU) || (st == STORE_SH);
        word = (lt == LOAD_LW) || (st == STORE_SW);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_lane.sv
// Combinational byte-lane logic: store data replication / strobes and load extract / extend.
module ysyx_22041211_lsu_lane
    import ysyx_22041211_lsu_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  store_type_i,
    input  logic [31:0] store_data_i,
    input  logic [2:0]  load_type_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    always_comb begin
        wdata_o = store_data_i;
        wstrb_o = 4'b0000;
        case (store_type_i)
            STORE_SB: begin
                wdata_o = {4{store_data_i[7:0]}};
                wstrb_o = 4'b0001 << offset_i;
            end
            STORE_SH: begin
                wdata_o = {2{store_data_i[15:0]}};
                wstrb_o = 4'b0011 << offset_i;
            end
            STORE_SW: wstrb_o = 4'b1111;
            default: ;
        endcase
    end

    // Bring the addressed byte/half down to bit 0; misaligned words lose their upper lanes.
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        case (load_type_i)
            LOAD_LB:  load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            LOAD_LBU: load_data_o = {24'h0, shifted[7:0]};
            LOAD_LH:  load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            LOAD_LHU: load_data_o = {16'h0, shifted[15:0]};
            default:  load_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_lsu_hs.sv
// Handshaked load/store unit between EXU and WBU with split request/response memory port.
// Optional misaligned-access trap enabled by YSYX_22041211_LSU_ALIGN_CHECK_EN.
module ysyx_22041211_lsu_hs
    import ysyx_22041211_lsu_pkg::*;
#(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned TMO_CYC  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                wd_i,
    input  logic [4:0]          wreg_i,
    input  logic [DATA_LEN-1:0] alu_result_i,
    input  logic [DATA_LEN-1:0] mem_wdata_i,
    input  logic [2:0]          load_type_i,
    input  logic [1:0]          store_type_i,
    input  logic [DATA_LEN-1:0] csr_wdata_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                wd_o,
    output logic [4:0]          wreg_o,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic [DATA_LEN-1:0] csr_wdata_o,
    output logic                err_o,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [ADDR_LEN-1:0] req_addr,
    output logic                req_wen,
    output logic [DATA_LEN-1:0] req_wdata,
    output logic [3:0]          req_wstrb,
    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic [DATA_LEN-1:0] rsp_rdata,
    input  logic                rsp_err
);

    localparam logic [31:0] TmoLast = 32'(TMO_CYC - 1);

    lsu_state_e          state_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] sdata_q;
    logic [2:0]          lt_q;
    logic [1:0]          st_q;
    logic [31:0]         cnt_q;
    logic                wd_q;
    logic [4:0]          wreg_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [DATA_LEN-1:0] csr_q;
    logic                err_q;

    logic                is_load;
    logic                is_mem;
    logic [1:0]          st_eff;
    logic                misalign;
    logic [DATA_LEN-1:0] ld_data;

    // Load wins when both types are set, so the store type is squashed at accept.
    assign is_load = load_type_i != LOAD_NONE;
    assign st_eff  = is_load ? STORE_NONE : store_type_i;
    assign is_mem  = is_load || (st_eff != STORE_NONE);

`ifdef YSYX_22041211_LSU_ALIGN_CHECK_EN
    assign misalign = is_misaligned(load_type_i, st_eff, alu_result_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    ysyx_22041211_lsu_lane u_lane (
        .offset_i     (addr_q[1:0]),
        .store_type_i (st_q),
        .store_data_i (sdata_q),
        .load_type_i  (lt_q),
        .rdata_i      (rsp_rdata),
        .wdata_o      (req_wdata),
        .wstrb_o      (req_wstrb),
        .load_data_o  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sdata_q <= '0;
            lt_q    <= LOAD_NONE;
            st_q    <= STORE_NONE;
            cnt_q   <= '0;
            wd_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            csr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    addr_q  <= alu_result_i[ADDR_LEN-1:0];
                    sdata_q <= mem_wdata_i;
                    lt_q    <= load_type_i;
                    st_q    <= st_eff;
                    wreg_q  <= wreg_i;
                    csr_q   <= csr_wdata_i;
                    wdata_q <= alu_result_i;
                    wd_q    <= wd_i && (st_eff == STORE_NONE);
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    if (!is_mem) begin
                        state_q <= S_DONE;
                    end else if (misalign) begin
                        state_q <= S_DONE;
                        err_q   <= 1'b1;
                        wd_q    <= 1'b0;
                        wdata_q <= '0;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: if (req_ready) begin
                    state_q <= S_RESP;
                    cnt_q   <= '0;
                end
                S_RESP: begin
                    if (rsp_valid) begin
                        if (lt_q != LOAD_NONE) wdata_q <= ld_data;
                        err_q   <= rsp_err;
                        if (rsp_err) wd_q <= 1'b0;
                        state_q <= S_DONE;
                    end else if ((TMO_CYC != 0) && (cnt_q == TmoLast)) begin
                        err_q   <= 1'b1;
                        wd_q    <= 1'b0;
                        wdata_q <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_DONE: if (out_ready) begin
                    state_q <= S_IDLE;
                    err_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = state_q == S_IDLE;
    assign req_valid   = state_q == S_REQ;
    assign rsp_ready   = state_q == S_RESP;
    assign out_valid   = state_q == S_DONE;
    assign req_addr    = {addr_q[ADDR_LEN-1:2], 2'b00};
    assign req_wen     = st_q != STORE_NONE;
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign wdata_o     = wdata_q;
    assign csr_wdata_o = csr_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ysyx_22041211_lsu_hs.sv
// Directed bench for ysyx_22041211_lsu_hs: vector table plus multi-cycle corner sequences.
module tb_ysyx_22041211_lsu_hs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wd_i = 1'b0;
    logic [4:0]  wreg_i = '0;
    logic [31:0] alu_result_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [2:0]  load_type_i = '0;
    logic [1:0]  store_type_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        wd_o;
    logic [4:0]  wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] csr_wdata_o;
    logic        err_o;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid = 1'b0;
    logic        rsp_ready;
    logic [31:0] rsp_rdata = '0;
    logic        rsp_err = 1'b0;

    always #5 clk = ~clk;

    ysyx_22041211_lsu_hs #(.DATA_LEN(32), .ADDR_LEN(32), .TMO_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i),
        .mem_wdata_i(mem_wdata_i), .load_type_i(load_type_i), .store_type_i(store_type_i),
        .csr_wdata_i(csr_wdata_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .csr_wdata_o(csr_wdata_o),
        .err_o(err_o),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        rerr;
        logic        exp_req;
        logic        exp_wen;
        logic [3:0]  exp_strb;
        logic        chk_reqw;
        logic [31:0] exp_reqw;
        logic        chk_out;
        logic [31:0] exp_out;
        logic        exp_wd;
        logic        exp_err;
    } vec_t;

    localparam int NVec = 12;
    vec_t vecs [NVec];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] wreg,
                         input logic [31:0] csr);
        in_valid = 1'b1; wd_i = 1'b1; wreg_i = wreg; alu_result_i = addr;
        mem_wdata_i = sdata; load_type_i = lt; store_type_i = st; csr_wdata_i = csr;
    endtask

    task automatic scramble();
        in_valid = 1'b0; wd_i = 1'b0; wreg_i = 5'h1f; alu_result_i = 32'hFFFF_FFFF;
        mem_wdata_i = 32'h5555_5555; load_type_i = 3'b000; store_type_i = 2'b00;
        csr_wdata_i = 32'h0BAD_0BAD;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive(v.lt, v.st, v.addr, v.sdata, 5'(i + 1), 32'hC000_0000 + 32'(i));
        chk($sformatf("v%0d in_ready", i), 32'(in_ready), 1);
        step();
        scramble();
        chk($sformatf("v%0d req_valid", i), 32'(req_valid), 32'(v.exp_req));
        if (v.exp_req) begin
            chk($sformatf("v%0d req_addr", i), req_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d req_wen", i), 32'(req_wen), 32'(v.exp_wen));
            chk($sformatf("v%0d req_wstrb", i), 32'(req_wstrb), 32'(v.exp_strb));
            if (v.chk_reqw) chk($sformatf("v%0d req_wdata", i), req_wdata, v.exp_reqw);
            req_ready = 1'b1;
            step();
            req_ready = 1'b0;
            chk($sformatf("v%0d rsp_ready", i), 32'(rsp_ready), 1);
            rsp_valid = 1'b1; rsp_rdata = v.rdata; rsp_err = v.rerr;
            step();
            rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = 32'h0;
        end
        chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
        if (v.chk_out) chk($sformatf("v%0d wdata_o", i), wdata_o, v.exp_out);
        chk($sformatf("v%0d wd_o", i), 32'(wd_o), 32'(v.exp_wd));
        chk($sformatf("v%0d err_o", i), 32'(err_o), 32'(v.exp_err));
        chk($sformatf("v%0d wreg_o", i), 32'(wreg_o), 32'(i + 1));
        chk($sformatf("v%0d csr_wdata_o", i), csr_wdata_o, 32'hC000_0000 + 32'(i));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk($sformatf("v%0d out_valid after hs", i), 32'(out_valid), 0);
        chk($sformatf("v%0d in_ready after hs", i), 32'(in_ready), 1);
    endtask

    initial begin
        //         lt    st    addr          sdata         rdata         re rq we strb  cw reqw
        //         co out           wd er
        vecs[0]  = '{3'd0, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0,
                     32'h0, 1'b1, 32'h0000_1234, 1'b1, 1'b0};
        vecs[1]  = '{3'd1, 2'd0, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0};
        vecs[2]  = '{3'd2, 2'd0, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b0, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'h0000_0080, 1'b1, 1'b0};
        vecs[3]  = '{3'd0, 2'd2, 32'h8000_0002, 32'hAAAA_BEEF, 32'h0, 1'b0, 1'b1, 1'b1, 4'hC,
                     1'b1, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{3'd3, 2'd0, 32'h8000_0002, 32'h0, 32'h8001_1234, 1'b0, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0};
        vecs[5]  = '{3'd4, 2'd0, 32'h8000_0000, 32'h0, 32'h8001_F234, 1'b0, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'h0000_F234, 1'b1, 1'b0};
        vecs[6]  = '{3'd5, 2'd0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[7]  = '{3'd0, 2'd1, 32'h8000_0001, 32'h1234_56A5, 32'h0, 1'b0, 1'b1, 1'b1, 4'h2,
                     1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{3'd0, 2'd3, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 1'b1, 4'hF,
                     1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 2'd0, 32'h8000_0000, 32'h0, 32'h0000_007F, 1'b1, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'h0000_007F, 1'b0, 1'b1};
        vecs[10] = '{3'd2, 2'd3, 32'h8000_0001, 32'h0, 32'h0000_AB00, 1'b0, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'h0000_00AB, 1'b1, 1'b0};
        vecs[11] = '{3'd1, 2'd0, 32'h8000_0002, 32'h0, 32'h0045_0000, 1'b0, 1'b1, 1'b0, 4'h0,
                     1'b0, 32'h0, 1'b1, 32'h0000_0045, 1'b1, 1'b0};

        step(); step();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset req_valid", 32'(req_valid), 0);
        chk("reset rsp_ready", 32'(rsp_ready), 0);
        chk("reset err_o", 32'(err_o), 0);
        chk("reset wdata_o", wdata_o, 0);

        for (int i = 0; i < NVec; i++) run_vec(i);

        // Backpressure on both the request and the output side.
        drive(3'd0, 2'd3, 32'h8000_0004, 32'h1122_3344, 5'd9, 32'h99);
        step();
        scramble();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp req_valid c%0d", k), 32'(req_valid), 1);
            chk($sformatf("bp req_addr c%0d", k), req_addr, 32'h8000_0004);
            chk($sformatf("bp req_wdata c%0d", k), req_wdata, 32'h1122_3344);
            chk($sformatf("bp req_wstrb c%0d", k), 32'(req_wstrb), 32'hF);
            chk($sformatf("bp in_ready c%0d", k), 32'(in_ready), 0);
            step();
        end
        req_ready = 1'b1; step(); req_ready = 1'b0;
        rsp_valid = 1'b1; step(); rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp out_valid c%0d", k), 32'(out_valid), 1);
            chk($sformatf("bp wd_o c%0d", k), 32'(wd_o), 0);
            chk($sformatf("bp wreg_o c%0d", k), 32'(wreg_o), 9);
            chk($sformatf("bp csr c%0d", k), csr_wdata_o, 32'h99);
            chk($sformatf("bp in_ready out c%0d", k), 32'(in_ready), 0);
            step();
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("bp in_ready after hs", 32'(in_ready), 1);

        // Timeout after four response cycles; a late response is ignored.
        drive(3'd5, 2'd0, 32'h8000_0010, 32'h0, 5'd3, 32'h0);
        step();
        scramble();
        req_ready = 1'b1; step(); req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tmo out_valid c%0d", k), 32'(out_valid), 0);
            chk($sformatf("tmo rsp_ready c%0d", k), 32'(rsp_ready), 1);
            step();
        end
        chk("tmo out_valid", 32'(out_valid), 1);
        chk("tmo err_o", 32'(err_o), 1);
        chk("tmo wdata_o", wdata_o, 0);
        chk("tmo wd_o", 32'(wd_o), 0);
        rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678;
        step();
        rsp_valid = 1'b0; rsp_rdata = 32'h0;
        chk("tmo late rsp_ready", 32'(rsp_ready), 0);
        chk("tmo late wdata_o", wdata_o, 0);
        chk("tmo late err_o", 32'(err_o), 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("tmo err cleared", 32'(err_o), 0);
        chk("tmo in_ready", 32'(in_ready), 1);

        // Misaligned word load.
        drive(3'd5, 2'd0, 32'h8000_0001, 32'h0, 5'd4, 32'h0);
        step();
        scramble();
`ifdef YSYX_22041211_LSU_ALIGN_CHECK_EN
        chk("mis req_valid", 32'(req_valid), 0);
        chk("mis out_valid", 32'(out_valid), 1);
        chk("mis err_o", 32'(err_o), 1);
        chk("mis wd_o", 32'(wd_o), 0);
`else
        chk("mis req_valid", 32'(req_valid), 1);
        chk("mis req_addr", req_addr, 32'h8000_0000);
        req_ready = 1'b1; step(); req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'h1122_3344; step(); rsp_valid = 1'b0;
        chk("mis out_valid", 32'(out_valid), 1);
        chk("mis err_o", 32'(err_o), 0);
`endif
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("mis in_ready", 32'(in_ready), 1);

        // Reset while waiting for a response.
        drive(3'd5, 2'd0, 32'h8000_0020, 32'h0, 5'd7, 32'h55);
        step();
        scramble();
        req_ready = 1'b1; step(); req_ready = 1'b0;
        chk("rst rsp_ready before", 32'(rsp_ready), 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst req_valid", 32'(req_valid), 0);
        chk("rst rsp_ready", 32'(rsp_ready), 0);
        chk("rst err_o", 32'(err_o), 0);
        chk("rst wd_o", 32'(wd_o), 0);
        chk("rst wreg_o", 32'(wreg_o), 0);
        chk("rst wdata_o", wdata_o, 0);
        chk("rst csr_wdata_o", csr_wdata_o, 0);
        rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_FFFF; step(); rsp_valid = 1'b0;
        chk("rst late out_valid", 32'(out_valid), 0);
        chk("rst late in_ready", 32'(in_ready), 1);
        chk("rst late wdata_o", wdata_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
